// File: rtl/qspi_flash_sched_if.sv
// Bundles the two requester ports, status outputs and the flash-side bus
// of qspi_flash_sched. The master side is the requesters plus the flash
// model; the slave side is the scheduler itself.
interface qspi_flash_sched_if;
  // requester 0
  logic       req0;
  logic [1:0] op0;
  logic [7:0] addr0;
  logic [7:0] wdata0;
  logic       gnt0;
  logic       done0;
  // requester 1
  logic       req1;
  logic [1:0] op1;
  logic [7:0] addr1;
  logic [7:0] wdata1;
  logic       gnt1;
  logic       done1;
  // shared status
  logic       err;
  logic [7:0] rdata;
  logic       busy;
  // flash side
  logic       fl_write_enable;
  logic       fl_read_enable;
  logic       fl_erase_enable;
  logic [7:0] fl_address;
  logic [7:0] fl_data_in;
  logic [7:0] fl_data_out;

  modport master (
    output req0, op0, addr0, wdata0,
    output req1, op1, addr1, wdata1,
    output fl_data_out,
    input  gnt0, done0, gnt1, done1, err, rdata, busy,
    input  fl_write_enable, fl_read_enable, fl_erase_enable,
    input  fl_address, fl_data_in
  );

  modport slave (
    input  req0, op0, addr0, wdata0,
    input  req1, op1, addr1, wdata1,
    input  fl_data_out,
    output gnt0, done0, gnt1, done1, err, rdata, busy,
    output fl_write_enable, fl_read_enable, fl_erase_enable,
    output fl_address, fl_data_in
  );
endinterface

// File: rtl/qspi_flash_sched.sv
// Two-requester flash operation scheduler. Round-robin arbitrates between
// requesters, issues a one-cycle read/write/erase strobe, waits a fixed
// per-operation latency, then reports completion (and read data) with a
// one-cycle done pulse. All outputs are registered.
module qspi_flash_sched #(
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 4,
  parameter int unsigned ERASE_LAT = 8
) (
  input logic                clk,
  input logic                reset,
  qspi_flash_sched_if.slave  bus
);

  if (READ_LAT < 1 || READ_LAT > 15) begin : g_bad_read_lat
    $error("READ_LAT out of range 1..15");
  end
  if (WRITE_LAT < 1 || WRITE_LAT > 15) begin : g_bad_write_lat
    $error("WRITE_LAT out of range 1..15");
  end
  if (ERASE_LAT < 1 || ERASE_LAT > 15) begin : g_bad_erase_lat
    $error("ERASE_LAT out of range 1..15");
  end

  localparam logic [3:0] READ_LAT_C  = 4'(READ_LAT);
  localparam logic [3:0] WRITE_LAT_C = 4'(WRITE_LAT);
  localparam logic [3:0] ERASE_LAT_C = 4'(ERASE_LAT);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic [1:0] op_q;
  logic       id_q;      // requester currently being served
  logic       last_gnt;  // requester granted most recently

  logic       gnt0_q, gnt1_q, done0_q, done1_q, err_q, busy_q;
  logic       wr_en_q, rd_en_q, er_en_q;
  logic [7:0] rdata_q, addr_q, din_q;

  logic       win;
  logic [1:0] win_op;
  logic [7:0] win_addr;
  logic [7:0] win_wdata;
  logic       any_req;

  // Round-robin pick: lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    win     = 1'b0;
    if (bus.req0 && bus.req1) begin
      win = ~last_gnt;
    end else if (bus.req1) begin
      win = 1'b1;
    end
    win_op    = win ? bus.op1    : bus.op0;
    win_addr  = win ? bus.addr1  : bus.addr0;
    win_wdata = win ? bus.wdata1 : bus.wdata0;
  end

  // Scheduler FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      op_q     <= '0;
      id_q     <= 1'b0;
      last_gnt <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      er_en_q  <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      din_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Strobes are launched together with the grant so they are
          // visible during the ISSUE cycle itself.
          if (any_req) begin
            state    <= ISSUE;
            busy_q   <= 1'b1;
            id_q     <= win;
            last_gnt <= win;
            op_q     <= win_op;
            gnt0_q   <= ~win;
            gnt1_q   <= win;
            addr_q   <= win_addr;
            din_q    <= (win_op == OP_WRITE) ? win_wdata : '0;
            rd_en_q  <= (win_op == OP_READ);
            wr_en_q  <= (win_op == OP_WRITE);
            er_en_q  <= (win_op == OP_ERASE);
          end
        end

        ISSUE: begin
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b0;
          er_en_q <= 1'b0;
          case (op_q)
            OP_READ:  begin state <= WAIT; wait_cnt <= READ_LAT_C;  end
            OP_WRITE: begin state <= WAIT; wait_cnt <= WRITE_LAT_C; end
            OP_ERASE: begin state <= WAIT; wait_cnt <= ERASE_LAT_C; end
            default: begin
              state   <= DONE;
              err_q   <= 1'b1;
              done0_q <= ~id_q;
              done1_q <= id_q;
            end
          endcase
        end

        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state   <= DONE;
            err_q   <= 1'b0;
            done0_q <= ~id_q;
            done1_q <= id_q;
            if (op_q == OP_READ) begin
              rdata_q <= bus.fl_data_out;
            end
          end
        end

        DONE: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          err_q   <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0            = gnt0_q;
  assign bus.gnt1            = gnt1_q;
  assign bus.done0           = done0_q;
  assign bus.done1           = done1_q;
  assign bus.err             = err_q;
  assign bus.rdata           = rdata_q;
  assign bus.busy            = busy_q;
  assign bus.fl_write_enable = wr_en_q;
  assign bus.fl_read_enable  = rd_en_q;
  assign bus.fl_erase_enable = er_en_q;
  assign bus.fl_address      = addr_q;
  assign bus.fl_data_in      = din_q;

endmodule

// File: tb/tb_qspi_flash_sched.sv
// Directed bench for qspi_flash_sched with default latencies (2/4/8).
module tb_qspi_flash_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  qspi_flash_sched_if bus ();

  qspi_flash_sched #(
    .READ_LAT (2),
    .WRITE_LAT(4),
    .ERASE_LAT(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.op0 = 2'b00; bus.addr0 = 8'h00; bus.wdata0 = 8'h00;
    bus.req1 = 1'b0; bus.op1 = 2'b00; bus.addr1 = 8'h00; bus.wdata1 = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.fl_data_out = 8'h00;
    reset = 1'b1;
    tick(); tick();
    tests++;
    if (bus.busy !== 1'b0 || bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 ||
        bus.done0 !== 1'b0 || bus.done1 !== 1'b0 || bus.err !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: busy=%b gnt=%b%b done=%b%b err=%b required all 0",
               bus.busy, bus.gnt1, bus.gnt0, bus.done1, bus.done0, bus.err);
    end
    tests++;
    if (bus.fl_read_enable !== 1'b0 || bus.fl_write_enable !== 1'b0 || bus.fl_erase_enable !== 1'b0 ||
        bus.rdata !== 8'h00 || bus.fl_address !== 8'h00 || bus.fl_data_in !== 8'h00) begin
      fails++;
      $display("FAIL reset_data: strobes=%b%b%b rdata=%h addr=%h din=%h required 000/00/00/00",
               bus.fl_read_enable, bus.fl_write_enable, bus.fl_erase_enable,
               bus.rdata, bus.fl_address, bus.fl_data_in);
    end
    reset = 1'b0;
  endtask

  task automatic test_read();
    bus.req0 = 1'b1; bus.op0 = 2'b00; bus.addr0 = 8'h12;
    bus.fl_data_out = 8'hA5;
    tick();  // cycle 1: ISSUE
    tests++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.fl_read_enable !== 1'b1 ||
        bus.fl_address !== 8'h12 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL read_issue: gnt0=%b gnt1=%b rd=%b addr=%h busy=%b required 1 0 1 12 1",
               bus.gnt0, bus.gnt1, bus.fl_read_enable, bus.fl_address, bus.busy);
    end
    bus.req0 = 1'b0;
    tick();  // cycle 2
    tick();  // cycle 3
    tests++;
    if (bus.done0 !== 1'b0 || bus.fl_read_enable !== 1'b0 || bus.gnt0 !== 1'b0) begin
      fails++;
      $display("FAIL read_wait: done0=%b rd=%b gnt0=%b required 0 0 0",
               bus.done0, bus.fl_read_enable, bus.gnt0);
    end
    tick();  // cycle 4: DONE
    tests++;
    if (bus.done0 !== 1'b1 || bus.done1 !== 1'b0 || bus.rdata !== 8'hA5 || bus.err !== 1'b0) begin
      fails++;
      $display("FAIL read_done: done0=%b done1=%b rdata=%h err=%b required 1 0 a5 0",
               bus.done0, bus.done1, bus.rdata, bus.err);
    end
    tick();  // cycle 5: IDLE
    tests++;
    if (bus.busy !== 1'b0 || bus.done0 !== 1'b0) begin
      fails++;
      $display("FAIL read_idle: busy=%b done0=%b required 0 0", bus.busy, bus.done0);
    end
  endtask

  task automatic test_write();
    int done_at = -1;
    int wr_pulses = 0;
    logic saw_gnt1 = 1'b0;
    bus.req1 = 1'b1; bus.op1 = 2'b01; bus.addr1 = 8'h30; bus.wdata1 = 8'h5C;
    bus.fl_data_out = 8'h77;
    for (int c = 1; c <= 20 && done_at < 0; c++) begin
      tick();
      if (bus.gnt1) begin
        saw_gnt1 = 1'b1;
        bus.req1 = 1'b0;
        tests++;
        if (c !== 1 || bus.fl_write_enable !== 1'b1 || bus.fl_data_in !== 8'h5C || bus.fl_address !== 8'h30) begin
          fails++;
          $display("FAIL write_issue: cycle=%0d wr=%b din=%h addr=%h required 1 1 5c 30",
                   c, bus.fl_write_enable, bus.fl_data_in, bus.fl_address);
        end
      end
      if (bus.fl_write_enable) wr_pulses++;
      if (bus.done1) done_at = c;
    end
    tests++;
    if (done_at !== 6 || !saw_gnt1) begin
      fails++;
      $display("FAIL write_latency: done1 at %0d (gnt seen %b) required 6", done_at, saw_gnt1);
    end
    tests++;
    if (wr_pulses !== 1 || bus.rdata !== 8'hA5 || bus.err !== 1'b0) begin
      fails++;
      $display("FAIL write_misc: pulses=%0d rdata=%h err=%b required 1 a5 0", wr_pulses, bus.rdata, bus.err);
    end
    tick();
    tests++;
    if (bus.fl_data_in !== 8'h5C || bus.fl_address !== 8'h30 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL write_hold: din=%h addr=%h busy=%b required 5c 30 0",
               bus.fl_data_in, bus.fl_address, bus.busy);
    end
  endtask

  task automatic test_illegal();
    bus.req0 = 1'b1; bus.op0 = 2'b11; bus.addr0 = 8'h44; bus.wdata0 = 8'hEE;
    bus.fl_data_out = 8'h99;
    tick();
    tests++;
    if (bus.gnt0 !== 1'b1 || bus.fl_read_enable !== 1'b0 ||
        bus.fl_write_enable !== 1'b0 || bus.fl_erase_enable !== 1'b0) begin
      fails++;
      $display("FAIL illegal_issue: gnt0=%b strobes=%b%b%b required 1 000",
               bus.gnt0, bus.fl_read_enable, bus.fl_write_enable, bus.fl_erase_enable);
    end
    bus.req0 = 1'b0;
    tick();
    tests++;
    if (bus.done0 !== 1'b1 || bus.err !== 1'b1 || bus.rdata !== 8'hA5) begin
      fails++;
      $display("FAIL illegal_done: done0=%b err=%b rdata=%h required 1 1 a5",
               bus.done0, bus.err, bus.rdata);
    end
    tick();
    tests++;
    if (bus.err !== 1'b0 || bus.done0 !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL illegal_after: err=%b done0=%b busy=%b required 0 0 0", bus.err, bus.done0, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int seq [4];
    int ngnt = 0;
    int multi = 0;
    test_reset();
    bus.req0 = 1'b1; bus.op0 = 2'b00; bus.addr0 = 8'h01;
    bus.req1 = 1'b1; bus.op1 = 2'b00; bus.addr1 = 8'h02;
    for (int c = 0; c < 60 && ngnt < 4; c++) begin
      tick();
      if (bus.gnt0 && bus.gnt1) multi++;
      if ((32'(bus.fl_read_enable) + 32'(bus.fl_write_enable) + 32'(bus.fl_erase_enable)) > 1) multi++;
      if (bus.done0 && bus.done1) multi++;
      if (bus.gnt0 && ngnt < 4) begin seq[ngnt] = 0; ngnt++; end
      else if (bus.gnt1 && ngnt < 4) begin seq[ngnt] = 1; ngnt++; end
    end
    tests++;
    if (ngnt !== 4 || seq[0] !== 0 || seq[1] !== 1 || seq[2] !== 0 || seq[3] !== 1) begin
      fails++;
      $display("FAIL rr_order: %0d grants, order %0d %0d %0d %0d required 4 grants 0 1 0 1",
               ngnt, seq[0], seq[1], seq[2], seq[3]);
    end
    tests++;
    if (multi !== 0) begin
      fails++;
      $display("FAIL rr_exclusive: %0d cycles with two gnt/strobe/done required 0", multi);
    end
    idle_inputs();
    for (int c = 0; c < 20 && bus.busy; c++) tick();
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int dones = 0;
    bus.req0 = 1'b1; bus.op0 = 2'b10; bus.addr0 = 8'h80;
    tick();  // ISSUE
    tests++;
    if (bus.fl_erase_enable !== 1'b1 || bus.fl_address !== 8'h80 || bus.fl_data_in !== 8'h00) begin
      fails++;
      $display("FAIL erase_issue: er=%b addr=%h din=%h required 1 80 00",
               bus.fl_erase_enable, bus.fl_address, bus.fl_data_in);
    end
    bus.req0 = 1'b0;
    tick(); tick(); tick();  // third WAIT cycle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (bus.busy !== 1'b0 || bus.done0 !== 1'b0 || bus.gnt0 !== 1'b0 || bus.err !== 1'b0 ||
        bus.fl_erase_enable !== 1'b0 || bus.fl_address !== 8'h00 || bus.rdata !== 8'h00) begin
      fails++;
      $display("FAIL abort_state: busy=%b done0=%b gnt0=%b err=%b er=%b addr=%h rdata=%h required 0 0 0 0 0 00 00",
               bus.busy, bus.done0, bus.gnt0, bus.err, bus.fl_erase_enable, bus.fl_address, bus.rdata);
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.done0 || bus.done1 || bus.busy) dones++;
    end
    tests++;
    if (dones !== 0) begin
      fails++;
      $display("FAIL abort_no_done: %0d cycles with done/busy required 0", dones);
    end
  endtask

  task automatic test_read_then_erase();
    int done_at = -1;
    bus.req1 = 1'b1; bus.op1 = 2'b00; bus.addr1 = 8'h21;
    bus.fl_data_out = 8'h3C;
    for (int c = 1; c <= 20 && done_at < 0; c++) begin
      tick();
      if (bus.gnt1) bus.req1 = 1'b0;
      if (bus.done1) done_at = c;
    end
    tests++;
    if (done_at !== 4 || bus.rdata !== 8'h3C) begin
      fails++;
      $display("FAIL rd_capture: done1 at %0d rdata=%h required 4 3c", done_at, bus.rdata);
    end
    tick();
    bus.fl_data_out = 8'hFF;
    bus.req1 = 1'b1; bus.op1 = 2'b10; bus.addr1 = 8'h22;
    done_at = -1;
    for (int c = 1; c <= 30 && done_at < 0; c++) begin
      tick();
      if (bus.gnt1) bus.req1 = 1'b0;
      if (bus.done1) done_at = c;
    end
    tests++;
    if (done_at !== 10 || bus.rdata !== 8'h3C || bus.err !== 1'b0) begin
      fails++;
      $display("FAIL erase_keeps_rdata: done1 at %0d rdata=%h err=%b required 10 3c 0",
               done_at, bus.rdata, bus.err);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_illegal();
    test_back_to_back();
    test_reset_mid_wait();
    test_read_then_erase();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
